// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: data-cache miss handler.
// On a miss it writes back the dirty victim block (if any), fetches the
// missing block from memory and presents it to the cache as a one-cycle
// fill. The pipeline is stalled for the whole transaction.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   miss, dirty     lookup missed / victim is dirty (sampled in IDLE only)
//   miss_addr       address of the missing access
//   victim_addr     victim block address
//   victim_data     victim block contents
//   stall           freeze pipeline (combinational)
//   fill_valid      one-cycle fill strobe, fill_addr / fill_data valid
//   mem_req/mem_we  memory request, 1 = block write, 0 = block read
//   mem_addr        block-aligned memory address
//   mem_wdata       write-back block
//   mem_ack         memory completes current request this cycle
//   mem_rdata       read block, valid with mem_ack on a read
//   bus_err         sticky: a memory request timed out
//   miss_cnt/wb_cnt free-running miss and write-back counters
module cache_refill_ctrl #(
   parameter int DATA_WIDTH  = 32,
   parameter int BLOCK_WIDTH = 4*DATA_WIDTH,
   parameter int TIMEOUT     = 64
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   miss,
   input  logic                   dirty,
   input  logic [DATA_WIDTH-1:0]  miss_addr,
   input  logic [DATA_WIDTH-1:0]  victim_addr,
   input  logic [BLOCK_WIDTH-1:0] victim_data,
   output logic                   stall,
   output logic                   fill_valid,
   output logic [DATA_WIDTH-1:0]  fill_addr,
   output logic [BLOCK_WIDTH-1:0] fill_data,
   output logic                   mem_req,
   output logic                   mem_we,
   output logic [DATA_WIDTH-1:0]  mem_addr,
   output logic [BLOCK_WIDTH-1:0] mem_wdata,
   input  logic                   mem_ack,
   input  logic [BLOCK_WIDTH-1:0] mem_rdata,
   output logic                   bus_err,
   output logic [31:0]            miss_cnt,
   output logic [31:0]            wb_cnt
);

   typedef enum logic [1:0] {IDLE, WB, FETCH, FILL} state_t;

   // Miss context captured in IDLE; busy-time input changes never reach it.
   typedef struct packed {
      logic [DATA_WIDTH-1:0]  maddr;
      logic [DATA_WIDTH-1:0]  vaddr;
      logic [BLOCK_WIDTH-1:0] vdata;
   } miss_ctx_t;

   // Last wait count before abort; unused when TIMEOUT is 0.
   localparam logic [31:0] TO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

   state_t    state, state_nx;
   miss_ctx_t ctx;
   logic [31:0] wait_cnt;
   logic        busy, timeout_hit, enter_req;

   function automatic logic [DATA_WIDTH-1:0] blk_align(input logic [DATA_WIDTH-1:0] a);
      return {a[DATA_WIDTH-1:4], 4'h0};
   endfunction

   assign busy        = (state == WB) || (state == FETCH);
   // Abort on the TIMEOUT-th consecutive un-acked request cycle.
   assign timeout_hit = (TIMEOUT != 0) && busy && !mem_ack && (wait_cnt == TO_LAST);
   assign enter_req   = (state_nx != state) && ((state_nx == WB) || (state_nx == FETCH));

   assign stall      = (state == IDLE) ? miss : 1'b1;
   assign fill_valid = (state == FILL);
   assign mem_wdata  = ctx.vdata;

   always_comb begin
      state_nx = state;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      mem_addr = ctx.maddr;
      unique case (state)
         IDLE:  if (miss) state_nx = dirty ? WB : FETCH;
         WB: begin
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            mem_addr = ctx.vaddr;
            if (mem_ack)          state_nx = FETCH;
            else if (timeout_hit) state_nx = IDLE;
         end
         FETCH: begin
            mem_req = 1'b1;
            if (mem_ack)          state_nx = FILL;
            else if (timeout_hit) state_nx = IDLE;
         end
         FILL:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ctx       <= '0;
         wait_cnt  <= '0;
         fill_addr <= '0;
         fill_data <= '0;
         bus_err   <= 1'b0;
         miss_cnt  <= '0;
         wb_cnt    <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && miss) begin
            ctx.maddr <= blk_align(miss_addr);
            ctx.vaddr <= blk_align(victim_addr);
            ctx.vdata <= victim_data;
            miss_cnt  <= miss_cnt + 32'd1;
            if (dirty) wb_cnt <= wb_cnt + 32'd1;
         end
         if (enter_req)           wait_cnt <= '0;
         else if (busy && !mem_ack) wait_cnt <= wait_cnt + 32'd1;
         if (state == FETCH && mem_ack) begin
            fill_data <= mem_rdata;
            fill_addr <= ctx.maddr;
         end
         if (timeout_hit) bus_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: table of miss transactions plus hand-written
// sequences (ack while idle, timeout, async reset mid-fetch, counter wrap).
// A latency-programmable memory model answers requests; expected fills go
// into a scoreboard queue and are popped when fill_valid is seen.
module tb_cache_refill_ctrl;
   localparam int DW = 32;
   localparam int BW = 128;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          miss = 1'b0, dirty = 1'b0;
   logic [DW-1:0] miss_addr = '0, victim_addr = '0;
   logic [BW-1:0] victim_data = '0;
   logic          stall, fill_valid, mem_req, mem_we, bus_err;
   logic [DW-1:0] fill_addr, mem_addr;
   logic [BW-1:0] fill_data, mem_wdata;
   logic          ack_auto = 1'b0, ack_force = 1'b0;
   logic [BW-1:0] mem_rdata = '0;
   logic [31:0]   miss_cnt, wb_cnt;

   cache_refill_ctrl #(.DATA_WIDTH(DW), .BLOCK_WIDTH(BW), .TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n), .miss(miss), .dirty(dirty),
      .miss_addr(miss_addr), .victim_addr(victim_addr), .victim_data(victim_data),
      .stall(stall), .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_data(fill_data),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(ack_auto | ack_force), .mem_rdata(mem_rdata),
      .bus_err(bus_err), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt));

   typedef struct {
      logic          dirty;
      logic [DW-1:0] maddr, vaddr;
      logic [BW-1:0] vdata, rdata;
      int            wb_lat, rd_lat;   // request cycles until ack, 0 = never
      logic [DW-1:0] exp_wb_addr, exp_rd_addr;
      int            exp_stall;
   } vec_t;

   typedef struct { logic [DW-1:0] addr; logic [BW-1:0] data; } fill_t;

   int            n_cmp = 0, n_err = 0;
   fill_t         sb_q[$];
   logic [31:0]   m_miss = '0, m_wb = '0;
   int            wb_lat = 1, rd_lat = 1, req_cyc = 0;
   logic [BW-1:0] rdata_val = '0, exp_wdata = '0;
   logic [DW-1:0] exp_wb_addr = '0, exp_rd_addr = '0;
   int            stall_cyc = 0, wb_cyc = 0;
   bit            phase_chk = 1'b0;
   vec_t          vecs[4];
   vec_t          to_vec;

   task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Memory model, request-phase checks and scoreboard, all sampled mid-cycle.
   always @(negedge clk) begin
      if (stall) stall_cyc++;
      if (phase_chk && mem_req) begin
         if (mem_we) begin
            wb_cyc++;
            chk("wb_addr", 128'(mem_addr), 128'(exp_wb_addr));
            chk("wb_data", mem_wdata, exp_wdata);
         end else
            chk("rd_addr", 128'(mem_addr), 128'(exp_rd_addr));
      end
      if (fill_valid) begin
         if (sb_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_fill: got addr %0h expected no fill", fill_addr);
         end else begin
            fill_t e;
            e = sb_q.pop_front();
            chk("fill_addr", 128'(fill_addr), 128'(e.addr));
            chk("fill_data", fill_data, e.data);
         end
      end
      if (!rst_n) begin
         ack_auto = 1'b0; req_cyc = 0;
      end else begin
         if (ack_auto) begin ack_auto = 1'b0; req_cyc = 0; end
         if (mem_req) begin
            int lat;
            lat = mem_we ? wb_lat : rd_lat;
            req_cyc++;
            if (lat != 0 && req_cyc >= lat) begin
               ack_auto  = 1'b1;
               mem_rdata = rdata_val;
            end
         end
      end
   end

   task automatic churn();
      dirty       = 1'($urandom);
      miss_addr   = $urandom;
      victim_addr = $urandom;
      victim_data = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic run_vec(input string tag, input vec_t v, input bit expect_fill);
      int guard;
      @(posedge clk); #2;
      wb_lat = v.wb_lat; rd_lat = v.rd_lat; rdata_val = v.rdata;
      exp_wb_addr = v.exp_wb_addr; exp_rd_addr = v.exp_rd_addr; exp_wdata = v.vdata;
      stall_cyc = 0; wb_cyc = 0; phase_chk = 1'b1;
      if (expect_fill) sb_q.push_back('{v.exp_rd_addr, v.rdata});
      miss = 1'b1; dirty = v.dirty; miss_addr = v.maddr;
      victim_addr = v.vaddr; victim_data = v.vdata;
      m_miss++;
      if (v.dirty) m_wb++;
      #1 chk({tag, "_stall_same_cycle"}, 128'(stall), 128'(1));
      @(posedge clk); #2;
      miss = 1'b0;
      churn();
      guard = 0;
      while (stall && guard < 100) begin
         @(posedge clk); #2;
         churn();
         guard++;
      end
      if (guard >= 100) begin
         n_cmp++; n_err++;
         $display("FAIL %s_done: stall still high after %0d cycles, expected release", tag, guard);
      end
      phase_chk = 1'b0;
      chk({tag, "_stall_cycles"}, 128'(stall_cyc), 128'(v.exp_stall));
      chk({tag, "_wb_cycles"}, 128'(wb_cyc), 128'(v.dirty ? v.wb_lat : 0));
      chk({tag, "_fill_pending"}, 128'(sb_q.size()), 128'(0));
      chk({tag, "_miss_cnt"}, 128'(miss_cnt), 128'(m_miss));
      chk({tag, "_wb_cnt"}, 128'(wb_cnt), 128'(m_wb));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, expected finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{1'b0, 32'h0000_1234, 32'h0, 128'h0,
                  128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA, 1, 1, 32'h0, 32'h0000_1230, 3};
      vecs[1] = '{1'b1, 32'h0000_3004, 32'h0000_2008, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                  128'h5A5A_5A5A_A5A5_A5A5_0F0F_0F0F_F0F0_F0F0, 3, 3, 32'h0000_2000, 32'h0000_3000, 8};
      vecs[2] = '{1'b1, 32'h0000_000F, 32'hFFFF_FFFF, {BW{1'b1}},
                  128'h1, 1, 1, 32'hFFFF_FFF0, 32'h0000_0000, 4};
      vecs[3] = '{1'b0, 32'hABCD_EF01, 32'h0000_4444, 128'h9,
                  128'hCAFE_BABE_DEAD_BEEF_0BAD_F00D_1234_5678, 1, 2, 32'h0, 32'hABCD_EF00, 4};
      to_vec  = '{1'b0, 32'h0000_7777, 32'h0, 128'h0, 128'h77, 1, 0, 32'h0, 32'h0000_7770, 5};

      // Reset state.
      #7;
      chk("rst_mem_req", 128'(mem_req), 128'(0));
      chk("rst_fill_valid", 128'(fill_valid), 128'(0));
      chk("rst_fill_addr", 128'(fill_addr), 128'(0));
      chk("rst_fill_data", fill_data, 128'(0));
      chk("rst_counters", 128'({miss_cnt, wb_cnt, 31'b0, bus_err}), 128'(0));
      @(posedge clk); #2 rst_n = 1'b1;

      run_vec("clean0", vecs[0], 1'b1);
      run_vec("dirty_lat3", vecs[1], 1'b1);
      chk("bus_err_clear", 128'(bus_err), 128'(0));

      // Ack while idle must be ignored.
      @(posedge clk); #2 ack_force = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #2;
         chk("idle_ack_req", 128'({mem_req, stall, fill_valid}), 128'(0));
         chk("idle_ack_miss_cnt", 128'(miss_cnt), 128'(m_miss));
      end
      ack_force = 1'b0;

      // Timeout: no ack for 4 request cycles aborts with no fill.
      run_vec("timeout", to_vec, 1'b0);
      chk("timeout_bus_err", 128'(bus_err), 128'(1));

      run_vec("dirty_edge", vecs[2], 1'b1);
      chk("bus_err_sticky", 128'(bus_err), 128'(1));

      // Async reset in the middle of a fetch.
      @(posedge clk); #2;
      rd_lat = 0; miss = 1'b1; dirty = 1'b0; miss_addr = 32'h0000_5550;
      @(posedge clk); #2 miss = 1'b0;
      @(posedge clk); #2;
      chk("pre_rst_req", 128'({mem_req, mem_we}), 128'(2'b10));
      rst_n = 1'b0;
      #1;
      chk("midrst_req_stall", 128'({mem_req, stall, fill_valid}), 128'(0));
      chk("midrst_bus_err", 128'(bus_err), 128'(0));
      chk("midrst_miss_cnt", 128'(miss_cnt), 128'(0));
      chk("midrst_wb_cnt", 128'(wb_cnt), 128'(0));
      m_miss = '0; m_wb = '0;
      @(posedge clk); #2 rst_n = 1'b1;

      run_vec("after_rst", vecs[3], 1'b1);

      // Counter wrap.
      @(posedge clk); #2;
      force dut.miss_cnt = 32'hFFFF_FFFF;
      #1 release dut.miss_cnt;
      m_miss = 32'hFFFF_FFFF;
      run_vec("wrap", vecs[0], 1'b1);
      chk("wrap_zero", 128'(miss_cnt), 128'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
